// File: rtl/mental_math_sequencer_if.sv
// Number-source handshake bus for mental_math_sequencer.
// master = sequencer (issues num_req); slave = number source.
interface mental_math_sequencer_if;
   logic       num_req;
   logic       num_ack;
   logic [4:0] num_data;

   modport master (output num_req, input num_ack, input num_data);
   modport slave  (input num_req, output num_ack, output num_data);
endinterface

// File: rtl/mental_math_sequencer.sv
// Round controller for the mental-math game: fetch operands, show them, time the answer, score it.
// Optional MMS_AUTO_RESTART_EN: RESULT loops straight back to FETCH instead of waiting for start.
module mental_math_sequencer #(
   parameter int unsigned NUM_TERMS     = 5,
   parameter int unsigned SHOW_CYCLES   = 2,
   parameter int unsigned ANSWER_CYCLES = 15,
   parameter int unsigned RESULT_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           submit,
   input  logic [6:0]                     switch,
   mental_math_sequencer_if.master        num_bus,
   output logic [7:0]                     disp_value,
   output logic [6:0]                     led,
   output logic [3:0]                     score,
   output logic                           round_done,
   output logic                           busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SHOW, S_GAP, S_ANSWER, S_CHECK, S_RESULT
   } state_t;

   state_t      state, state_n;
   logic [4:0]  operand, operand_n;
   logic [7:0]  sum, sum_n, sum_mod;
   logic [3:0]  term_cnt, term_cnt_n;
   logic [15:0] timer, timer_n;
   logic [6:0]  ans, ans_n;
   logic        correct_q, correct_n;
   logic [3:0]  score_n;
   logic [7:0]  disp_n;
   logic [6:0]  led_n;
   logic        round_done_n, busy_n, num_req_q, num_req_n;

   assign num_bus.num_req = num_req_q;

   // sum never exceeds 8*31 = 248, so two conditional subtractions give sum % 100
   always_comb begin
      if (sum >= 8'd200)      sum_mod = sum - 8'd200;
      else if (sum >= 8'd100) sum_mod = sum - 8'd100;
      else                    sum_mod = sum;
   end

   always_comb begin
      state_n      = state;
      operand_n    = operand;
      sum_n        = sum;
      term_cnt_n   = term_cnt;
      timer_n      = timer;
      ans_n        = ans;
      correct_n    = correct_q;
      score_n      = score;
      round_done_n = 1'b0;

      case (state)
         S_IDLE: if (start) begin
            sum_n      = '0;
            term_cnt_n = '0;
            state_n    = S_FETCH;
         end
         S_FETCH: if (num_bus.num_ack) begin
            operand_n = num_bus.num_data;
            sum_n     = sum + {3'b000, num_bus.num_data};
            timer_n   = 16'(SHOW_CYCLES - 1);
            state_n   = S_SHOW;
         end
         S_SHOW: if (timer == '0) begin
            term_cnt_n = term_cnt + 4'd1;
            state_n    = S_GAP;
         end else begin
            timer_n = timer - 16'd1;
         end
         S_GAP: if (term_cnt == 4'(NUM_TERMS)) begin
            timer_n = 16'(ANSWER_CYCLES - 1);
            state_n = S_ANSWER;
         end else begin
            state_n = S_FETCH;
         end
         S_ANSWER: if (submit || timer == '0) begin
            ans_n   = switch;
            state_n = S_CHECK;
         end else begin
            timer_n = timer - 16'd1;
         end
         S_CHECK: begin
            correct_n = ({1'b0, ans} == sum_mod);
            if (correct_n && score != 4'hF) score_n = score + 4'd1;
            timer_n = 16'(RESULT_CYCLES - 1);
            state_n = S_RESULT;
         end
         S_RESULT: if (timer == '0) begin
            round_done_n = 1'b1;
`ifdef MMS_AUTO_RESTART_EN
            sum_n      = '0;
            term_cnt_n = '0;
            state_n    = S_FETCH;
`else
            state_n    = S_IDLE;
`endif
         end else begin
            timer_n = timer - 16'd1;
         end
         default: state_n = S_IDLE;
      endcase

      // outputs are decoded from the next state so the registered values line up with it
      num_req_n = (state_n == S_FETCH);
      busy_n    = (state_n != S_IDLE);
      disp_n    = '0;
      led_n     = '0;
      case (state_n)
         S_SHOW: begin
            disp_n = {3'b000, operand_n};
            led_n  = {operand_n, 2'b00};
         end
         S_ANSWER: disp_n = {1'b0, switch};
         S_RESULT: begin
            disp_n = sum_mod;
            led_n  = correct_n ? 7'h7F : 7'h55;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         operand    <= '0;
         sum        <= '0;
         term_cnt   <= '0;
         timer      <= '0;
         ans        <= '0;
         correct_q  <= 1'b0;
         score      <= '0;
         disp_value <= '0;
         led        <= '0;
         round_done <= 1'b0;
         busy       <= 1'b0;
         num_req_q  <= 1'b0;
      end else begin
         state      <= state_n;
         operand    <= operand_n;
         sum        <= sum_n;
         term_cnt   <= term_cnt_n;
         timer      <= timer_n;
         ans        <= ans_n;
         correct_q  <= correct_n;
         score      <= score_n;
         disp_value <= disp_n;
         led        <= led_n;
         round_done <= round_done_n;
         busy       <= busy_n;
         num_req_q  <= num_req_n;
      end
   end

endmodule

// File: doc/mental_math_sequencer.md
Name: mental_math_sequencer

Overview:
- Round controller for the mental-math game datapath.
- Requests operands from an external number source over a req/ack handshake, presents each operand for a fixed time, then opens a timed answer window on the switches.
- Checks the answer against the running sum mod 100 and shows the result.
- Keeps a saturating score and drives the value that feeds binary_to_bcd, plus the LED bank.

Parameters:
- NUM_TERMS, 5, operands per round; legal range 1..8.
- SHOW_CYCLES, 2, cycles each operand is displayed; must be >= 1.
- ANSWER_CYCLES, 15, answer-window length in cycles before timeout; must be >= 1.
- RESULT_CYCLES, 4, cycles the result is displayed; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  level; sampled only in IDLE
- submit  input  1  level; sampled only in ANSWER
- switch  input  7  user answer
- num_req  output  1  operand request to number source
- num_ack  input  1  number source has valid num_data this cycle
- num_data  input  5  operand value, 0..31
- disp_value  output  8  binary value to the BCD converter
- led  output  7  LED bank
- score  output  4  correct rounds, saturating at 15
- round_done  output  1  one-cycle pulse when a round ends
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high) forces: state IDLE, disp_value 0, led 0, score 0, num_req 0, round_done 0, sum 0, term count 0, all timers 0. Reset mid-round abandons the round; no pulses are emitted.
- All outputs are registered. Every state transition takes 1 clk edge.
- IDLE: disp_value 0, led 0.
  - If start=1, clear sum and term count, then go to FETCH.
- FETCH: num_req=1, held until num_ack=1 in the same cycle.
  - On ack: capture num_data, sum <= sum + {3'b0,num_data}, load the show timer with SHOW_CYCLES-1, go to SHOW.
  - Deassert num_req on the cycle after ack.
  - num_ack in any other state is ignored.
- SHOW: disp_value={3'b0,operand}, led={operand,2'b00}.
  - Decrement the timer. When it reaches 0, go to GAP and increment the term count.
- GAP: exactly 1 cycle with disp_value 0 and led 0, so repeated equal operands stay distinguishable.
  - If term count == NUM_TERMS, load the answer timer with ANSWER_CYCLES-1 and go to ANSWER; otherwise go to FETCH.
- ANSWER: disp_value={1'b0,switch} live, led 0.
  - If submit=1 or the timer reaches 0, latch switch into ans and go to CHECK.
  - If submit and timeout occur in the same cycle, treat it as submit; the outcome is identical.
- CHECK: 1 cycle.
  - correct = ({1'b0,ans} == sum % 100). sum is 8 bits; max 8*31=248, so there is no overflow.
  - If correct and score<15, score+1. At 15, score holds.
  - Load the result timer with RESULT_CYCLES-1, go to RESULT.
- RESULT: disp_value = sum % 100; led = 7'h7F if correct, else 7'h55.
  - When the timer reaches 0: pulse round_done for 1 cycle, drive led 0, go to IDLE.
- start outside IDLE and submit outside ANSWER are ignored.
- A num_data value of 0 is legal.

Optional Feature:
- Macro: MMS_AUTO_RESTART_EN.
- When defined, RESULT exits directly to FETCH (sum and term count cleared) instead of IDLE, and round_done still pulses. Rounds repeat continuously until rst. start is needed only for the first round after reset.
- When undefined, RESULT returns to IDLE and every round requires start.

Test Plan:
- Correct answer (defaults): start=1 for 1 cycle; ack operands 3,5,7,9,11 → each shown for 2 cycles with a 1-cycle 0 gap; sum=35. switch=35, submit → disp_value 35, led 7F for 4 cycles, score 1, one round_done pulse.
- Mod-100 boundary: operands 21,11,23,15,30 (sum 100), switch=0, no submit → timeout after 15 ANSWER cycles → disp_value 0, led 7F, score +1.
- Wrong answer and handshake stall: operands 31×5 (sum 155→55); delay num_ack 3 cycles on the 2nd operand → num_req held high throughout, no operand skipped. switch=54 → led 55, score unchanged.
- Score saturation: 16 consecutive correct rounds → score stays 15 on round 16. start pulsed during SHOW is ignored and busy stays 1.
- Reset mid-round: assert rst during ANSWER → same-cycle outputs 0, score 0, state IDLE, no round_done.
- With MMS_AUTO_RESTART_EN defined: after RESULT, num_req rises within 1 cycle with no start input. Without it, the design stays in IDLE.
